// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline hazard bus: stage register selects and write flags in, stall/flush/forward controls out.
// The hazard unit sits on the slave modport; the pipeline (or a testbench) on the master modport.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rsel1_dec;
  logic [REG_AW-1:0] rsel2_dec;
  logic [REG_AW-1:0] rsel1_ex;
  logic [REG_AW-1:0] rsel2_ex;
  logic [REG_AW-1:0] wsel_ex;
  logic [REG_AW-1:0] wsel_mem;
  logic [REG_AW-1:0] wsel_wb;
  logic              wen_ex;
  logic              wen_mem;
  logic              wen_wb;
  logic              memread_ex;
  logic              dmem_req;
  logic              dhit;
  logic              ihit;
  logic              branch_taken;
  logic              clr_perf;

  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cycles;

  // FSM observation: state (0 = RUN, 1 = LDUSE) and remaining load-use count
  logic              state_dbg;
  logic [2:0]        lu_cnt_dbg;

  modport master (
    output rsel1_dec, rsel2_dec, rsel1_ex, rsel2_ex, wsel_ex, wsel_mem, wsel_wb,
           wen_ex, wen_mem, wen_wb, memread_ex, dmem_req, dhit, ihit,
           branch_taken, clr_perf,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, stall, stall_cycles, state_dbg, lu_cnt_dbg
  );

  modport slave (
    input  rsel1_dec, rsel2_dec, rsel1_ex, rsel2_ex, wsel_ex, wsel_mem, wsel_wb,
           wen_ex, wen_mem, wen_wb, memread_ex, dmem_req, dhit, ihit,
           branch_taken, clr_perf,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, stall, stall_cycles, state_dbg, lu_cnt_dbg
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: stalls, flushes, forwarding select and a stall-cycle counter.
// HAZARD_FWD_EN defined: EX forwarding plus LD_LAT-cycle load-use stall; undefined: RAW interlock only.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int LD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  hazard_ctrl_unit_if.slave bus
);

  localparam int LCW = $clog2(LD_LAT + 1);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] LDUSE = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [LCW-1:0]   lu_cnt, lu_cnt_nxt;
  logic             dfreeze;
  logic             hazard;
  logic [1:0]       fwd_a_c, fwd_b_c;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cnt;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic match(input logic wen, input logic [REG_AW-1:0] wsel,
                                 input logic [REG_AW-1:0] r);
    return wen && (wsel != '0) && (wsel == r);
  endfunction

  assign dfreeze = bus.dmem_req & ~bus.dhit;

`ifdef HAZARD_FWD_EN
  logic lu_run;

  assign lu_run = bus.memread_ex & (match(bus.wen_ex, bus.wsel_ex, bus.rsel1_dec) |
                                    match(bus.wen_ex, bus.wsel_ex, bus.rsel2_dec));
  // Once in LDUSE the bubble count is committed; the decode operands are not re-checked.
  assign hazard = (state == LDUSE) | lu_run;

  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (match(bus.wen_mem, bus.wsel_mem, bus.rsel1_ex))     fwd_a_c = 2'b01;
    else if (match(bus.wen_wb, bus.wsel_wb, bus.rsel1_ex))  fwd_a_c = 2'b10;
    if (match(bus.wen_mem, bus.wsel_mem, bus.rsel2_ex))     fwd_b_c = 2'b01;
    else if (match(bus.wen_wb, bus.wsel_wb, bus.rsel2_ex))  fwd_b_c = 2'b10;
  end

  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    if (!dfreeze) begin
      if (bus.branch_taken) begin
        state_nxt  = RUN;
        lu_cnt_nxt = '0;
      end else if (state == LDUSE) begin
        if (lu_cnt == LCW'(1)) begin
          state_nxt  = RUN;
          lu_cnt_nxt = '0;
        end else begin
          lu_cnt_nxt = lu_cnt - LCW'(1);
        end
      end else if (lu_run && (LD_LAT > 1)) begin
        state_nxt  = LDUSE;
        lu_cnt_nxt = LCW'(LD_LAT - 1);
      end
    end
  end
`else
  // Without forwarding every in-flight producer in EX or MEM must retire first.
  assign hazard = match(bus.wen_ex,  bus.wsel_ex,  bus.rsel1_dec) |
                  match(bus.wen_ex,  bus.wsel_ex,  bus.rsel2_dec) |
                  match(bus.wen_mem, bus.wsel_mem, bus.rsel1_dec) |
                  match(bus.wen_mem, bus.wsel_mem, bus.rsel2_dec);
  assign fwd_a_c = 2'b00;
  assign fwd_b_c = 2'b00;

  always_comb begin
    state_nxt  = RUN;
    lu_cnt_nxt = '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dfreeze) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
    end else if (bus.branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      // Hold PC and IF/ID; ID/EX still loads, but loads a bubble.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                              stall_cnt <= '0;
    else if (bus.clr_perf)                stall_cnt <= '0;
    else if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.fwd_a        = RST ? 2'b00 : fwd_a_c;
  assign bus.fwd_b        = RST ? 2'b00 : fwd_b_c;
  assign bus.stall        = ~pc_en;
  assign bus.stall_cycles = stall_cnt;
  assign bus.state_dbg    = state;
  assign bus.lu_cnt_dbg   = 3'(lu_cnt);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (LD_LAT=3, 4-bit counter to reach saturation quickly).
// Covers both builds: HAZARD_FWD_EN-only scenarios are guarded by the same macro.
module tb_hazard_ctrl_unit;
  localparam int REG_AW = 5;
  localparam int LD_LAT = 3;
  localparam int CNT_W  = 4;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall}
  localparam logic [11:0] V_NORMAL = {5'b11111, 2'b00, 4'b0000, 1'b0};
  localparam logic [11:0] V_RESET  = {5'b00000, 2'b11, 4'b0000, 1'b1};
  localparam logic [11:0] V_FREEZE = {5'b00000, 2'b00, 4'b0000, 1'b1};
  localparam logic [11:0] V_BRANCH = {5'b11111, 2'b11, 4'b0000, 1'b0};
  localparam logic [11:0] V_LU     = {5'b00111, 2'b01, 4'b0000, 1'b1};
  localparam logic [11:0] V_IMISS  = {5'b01111, 2'b10, 4'b0000, 1'b1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(.REG_AW(REG_AW), .LD_LAT(LD_LAT), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  logic [11:0]      exp_q[$];
  logic [11:0]      got_e;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               lu_left = 0;
  int               checks  = 0;
  int               errors  = 0;

  function automatic logic [11:0] obs();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b, bus.stall};
  endfunction

  function automatic logic m(input logic w, input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] r);
    return w && (s != 0) && (s == r);
  endfunction

  // Reference model of the combinational outputs from the current inputs and modelled stall state.
  function automatic logic [11:0] model();
    logic       haz;
    logic [1:0] fa, fb;
    fa = 2'b00;
    fb = 2'b00;
`ifdef HAZARD_FWD_EN
    haz = (lu_left > 0) || (bus.memread_ex && (m(bus.wen_ex, bus.wsel_ex, bus.rsel1_dec) ||
                                               m(bus.wen_ex, bus.wsel_ex, bus.rsel2_dec)));
    if (m(bus.wen_mem, bus.wsel_mem, bus.rsel1_ex))     fa = 2'b01;
    else if (m(bus.wen_wb, bus.wsel_wb, bus.rsel1_ex))  fa = 2'b10;
    if (m(bus.wen_mem, bus.wsel_mem, bus.rsel2_ex))     fb = 2'b01;
    else if (m(bus.wen_wb, bus.wsel_wb, bus.rsel2_ex))  fb = 2'b10;
`else
    haz = m(bus.wen_ex, bus.wsel_ex, bus.rsel1_dec)  || m(bus.wen_ex, bus.wsel_ex, bus.rsel2_dec) ||
          m(bus.wen_mem, bus.wsel_mem, bus.rsel1_dec) || m(bus.wen_mem, bus.wsel_mem, bus.rsel2_dec);
`endif
    if (rst)                              return V_RESET;
    if (bus.dmem_req && !bus.dhit)        return V_FREEZE | {7'b0, fa, fb, 1'b0};
    if (bus.branch_taken)                 return V_BRANCH | {7'b0, fa, fb, 1'b0};
    if (haz)                              return V_LU     | {7'b0, fa, fb, 1'b0};
    if (!bus.ihit)                        return V_IMISS  | {7'b0, fa, fb, 1'b0};
    return V_NORMAL | {7'b0, fa, fb, 1'b0};
  endfunction

  task automatic idle();
    bus.rsel1_dec = '0; bus.rsel2_dec = '0; bus.rsel1_ex = '0; bus.rsel2_ex = '0;
    bus.wsel_ex = '0; bus.wsel_mem = '0; bus.wsel_wb = '0;
    bus.wen_ex = 1'b0; bus.wen_mem = 1'b0; bus.wen_wb = 1'b0;
    bus.memread_ex = 1'b0; bus.dmem_req = 1'b0; bus.dhit = 1'b1; bus.ihit = 1'b1;
    bus.branch_taken = 1'b0; bus.clr_perf = 1'b0;
  endtask

  // Driver: queue the expected control word, then let the combinational outputs settle.
  task automatic drive(input logic [11:0] e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Advance one clock, updating the counter and load-use models from the expected word.
  task automatic tick(input logic [11:0] e);
`ifdef HAZARD_FWD_EN
    logic lu_now;
    lu_now = bus.memread_ex && (m(bus.wen_ex, bus.wsel_ex, bus.rsel1_dec) ||
                                m(bus.wen_ex, bus.wsel_ex, bus.rsel2_dec));
    if (rst)                            lu_left = 0;
    else if (bus.dmem_req && !bus.dhit) lu_left = lu_left;
    else if (bus.branch_taken)          lu_left = 0;
    else if (lu_left > 0)               lu_left = lu_left - 1;
    else if (lu_now)                    lu_left = LD_LAT - 1;
`endif
    if (rst || bus.clr_perf)              exp_cnt = '0;
    else if (!e[11] && (exp_cnt != '1))   exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.wen_ex = 1'b1; bus.wsel_ex = 5'd4; bus.rsel1_dec = 5'd4; bus.memread_ex = 1'b1;
      bus.ihit = (i != 1); bus.branch_taken = (i == 2);
      bus.wen_mem = 1'b1; bus.wsel_mem = 5'd2; bus.rsel1_ex = 5'd2;
      drive(V_RESET);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL reset_outputs step %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
    end
    checks++;
    if (bus.stall_cycles !== '0 || bus.state_dbg !== 1'b0) begin
      errors++; $display("FAIL reset_state got cnt %0d st %0d exp 0 0", bus.stall_cycles, bus.state_dbg);
    end
    rst = 1'b0;
    idle();
    drive(V_NORMAL);
    got_e = exp_q.pop_front();
    checks++;
    if (obs() !== got_e) begin
      errors++; $display("FAIL post_reset_normal got %h exp %h", obs(), got_e);
    end
    tick(got_e);
  endtask

`ifndef HAZARD_FWD_EN
  task automatic test_priority();
    logic [11:0] e;
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0: begin bus.wen_ex = 1'b1; e = V_NORMAL; end
        1: begin bus.wsel_ex = 5'd4; bus.rsel1_dec = 5'd4; e = V_NORMAL; end
        2: begin bus.wen_wb = 1'b1; bus.wsel_wb = 5'd4; bus.rsel1_dec = 5'd4; e = V_NORMAL; end
        3: begin bus.ihit = 1'b0; e = V_IMISS; end
        4: begin bus.ihit = 1'b0; bus.wen_ex = 1'b1; bus.wsel_ex = 5'd2; bus.rsel2_dec = 5'd2; e = V_LU; end
        5: begin bus.dmem_req = 1'b1; bus.dhit = 1'b0; bus.branch_taken = 1'b1; bus.ihit = 1'b0;
                 bus.wen_ex = 1'b1; bus.wsel_ex = 5'd2; bus.rsel2_dec = 5'd2; e = V_FREEZE; end
        6: begin bus.branch_taken = 1'b1; bus.ihit = 1'b0;
                 bus.wen_ex = 1'b1; bus.wsel_ex = 5'd2; bus.rsel2_dec = 5'd2; e = V_BRANCH; end
        default: begin bus.dmem_req = 1'b1; e = V_NORMAL; end
      endcase
      drive(e);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL priority case %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
    end
  endtask

  task automatic test_raw_stall();
    logic [11:0] e;
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.rsel1_ex = 5'd3; bus.rsel2_ex = 5'd3;
      if (i < 3) begin
        bus.wen_mem = 1'b1; bus.wsel_mem = 5'd3; bus.rsel2_dec = 5'd3; e = V_LU;
      end else if (i == 3) begin
        bus.wsel_mem = 5'd3; bus.rsel2_dec = 5'd3; e = V_NORMAL;
      end else if (i < 6) begin
        bus.wen_ex = 1'b1; bus.wsel_ex = 5'd6; bus.rsel1_dec = 5'd6;
        bus.clr_perf = (i == 5); e = V_LU;
      end else begin
        e = V_NORMAL;
      end
      drive(e);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL raw_stall step %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
      checks++;
      if (bus.stall_cycles !== exp_cnt) begin
        errors++; $display("FAIL raw_stall_cnt step %0d got %0d exp %0d", i, bus.stall_cycles, exp_cnt);
      end
    end
  endtask
`else
  task automatic test_load_use();
    logic [11:0] e;
    // Rows 0-3: plain LU; 4-9: LU with a 2-cycle data freeze; 10-11: branch; 12-14: reset mid-LDUSE.
    for (int i = 0; i < 15; i++) begin
      idle();
      case (i)
        0, 4, 10, 12: begin
          bus.memread_ex = 1'b1; bus.wen_ex = 1'b1; bus.wsel_ex = 5'd5; bus.rsel1_dec = 5'd5;
          if (i == 10) begin bus.branch_taken = 1'b1; bus.ihit = 1'b0; e = V_BRANCH; end
          else e = V_LU;
        end
        1, 2, 7, 8: e = V_LU;
        5, 6: begin bus.dmem_req = 1'b1; bus.dhit = 1'b0; e = V_FREEZE; end
        13: begin rst = 1'b1; e = V_RESET; end
        default: e = V_NORMAL;
      endcase
      if (i != 13) rst = 1'b0;
      drive(e);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL load_use step %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
      checks++;
      if (bus.stall_cycles !== exp_cnt || bus.state_dbg !== (lu_left > 0)) begin
        errors++; $display("FAIL load_use_state step %0d got cnt %0d st %0d exp cnt %0d st %0d",
                           i, bus.stall_cycles, bus.state_dbg, exp_cnt, (lu_left > 0));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [11:0] e;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.wen_mem = 1'b1; bus.wsel_mem = (i == 1) ? 5'd0 : 5'd7;
      bus.wen_wb = 1'b1; bus.wsel_wb = 5'd7; bus.rsel1_ex = 5'd7;
      bus.rsel2_ex = (i == 2) ? 5'd7 : 5'd0;
      case (i)
        0: e = V_NORMAL | 12'h008;
        1: e = V_NORMAL | 12'h010;
        default: e = V_NORMAL | 12'h00A;
      endcase
      drive(e);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL forwarding case %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
    end
  endtask
`endif

  task automatic test_counter();
    for (int i = 0; i < 22; i++) begin
      idle();
      bus.ihit = (i >= 20);
      bus.clr_perf = (i == 0) || (i == 18);
      drive(bus.ihit ? V_NORMAL : V_IMISS);
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL counter_outputs step %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
      checks++;
      if (bus.stall_cycles !== exp_cnt) begin
        errors++; $display("FAIL counter_value step %0d got %0d exp %0d", i, bus.stall_cycles, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.rsel1_dec = REG_AW'($urandom_range(0, 3));
      bus.rsel2_dec = REG_AW'($urandom_range(0, 3));
      bus.rsel1_ex  = REG_AW'($urandom_range(0, 3));
      bus.rsel2_ex  = REG_AW'($urandom_range(0, 3));
      bus.wsel_ex   = REG_AW'($urandom_range(0, 3));
      bus.wsel_mem  = REG_AW'($urandom_range(0, 3));
      bus.wsel_wb   = REG_AW'($urandom_range(0, 3));
      bus.wen_ex    = 1'($urandom_range(0, 1));
      bus.wen_mem   = 1'($urandom_range(0, 1));
      bus.wen_wb    = 1'($urandom_range(0, 1));
      bus.memread_ex   = ($urandom_range(0, 3) == 0);
      bus.dmem_req     = ($urandom_range(0, 3) == 0);
      bus.dhit         = 1'($urandom_range(0, 1));
      bus.ihit         = ($urandom_range(0, 3) != 0);
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.clr_perf     = ($urandom_range(0, 15) == 0);
      drive(model());
      got_e = exp_q.pop_front();
      checks++;
      if (obs() !== got_e) begin
        errors++; $display("FAIL random_outputs cyc %0d got %h exp %h", i, obs(), got_e);
      end
      tick(got_e);
      checks++;
      if (bus.stall_cycles !== exp_cnt) begin
        errors++; $display("FAIL random_cnt cyc %0d got %0d exp %0d", i, bus.stall_cycles, exp_cnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
`ifndef HAZARD_FWD_EN
    test_priority();
    test_raw_stall();
`else
    test_load_use();
    test_forwarding();
`endif
    test_counter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
